gin_packet_sequencer: RTL

- Hardware source for ml_accelerator's GIN packet and scan-chain inputs; replaces bench-driven stimulus.
- On start it optionally programs the ifmap/filter scan-chain tag IDs from an internal tag table.
- It then streams {row_tag, col_tag, data} packets from external synchronous-read ifmap/filter buffers, one pass per filter column, followed by a drain window.
- Sits between the on-chip buffers and ml_accelerator.

---
 rtl/gin_packet_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/gin_packet_sequencer.sv
`timescale 1ns/1ps
// GIN packet sequencer: optionally programs scan-chain tag IDs from an internal table,
// then streams {row_tag, col_tag, data} packets from the ifmap/filter buffers.
module gin_packet_sequencer #(
  parameter int BITWIDTH      = 16,
  parameter int TAG_LENGTH    = 4,
  parameter int PE_Y_SIZE     = 3,
  parameter int PE_X_SIZE     = 3,
  parameter int PACKET_LENGTH = 2*TAG_LENGTH+BITWIDTH,
  parameter int ADDR_WIDTH    = 8,
  parameter int HOLD_CYCLES   = 2,
  parameter int DRAIN_CYCLES  = 6
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     start,
  input  logic                     cfg_prog_en,
  input  logic [TAG_LENGTH-1:0]    cfg_row_tag,
  input  logic                     cfg_wr_en,
  input  logic [TAG_LENGTH-1:0]    cfg_wr_addr,
  input  logic [TAG_LENGTH-1:0]    cfg_wr_ifmap_id,
  input  logic [TAG_LENGTH-1:0]    cfg_wr_filter_id,
  output logic [ADDR_WIDTH-1:0]    ifmap_addr,
  input  logic [BITWIDTH-1:0]      ifmap_rdata,
  output logic [ADDR_WIDTH-1:0]    filter_addr,
  input  logic [BITWIDTH-1:0]      filter_rdata,
  output logic                     program_en,
  output logic [TAG_LENGTH-1:0]    scan_chain_input_ifmap,
  output logic [TAG_LENGTH-1:0]    scan_chain_input_filter,
  output logic                     pe_reset,
  output logic                     gin_enable_ifmap,
  output logic                     gin_enable_filter,
  output logic [PACKET_LENGTH-1:0] data_packet_ifmap,
  output logic [PACKET_LENGTH-1:0] data_packet_filter,
  output logic                     busy,
  output logic                     done
);

  localparam int SCAN_LEN = PE_Y_SIZE*PE_X_SIZE + PE_X_SIZE;
  localparam int IF_LEN   = PE_X_SIZE + PE_Y_SIZE - 1;
  localparam int SW = (SCAN_LEN > 1)     ? $clog2(SCAN_LEN)     : 1;
  localparam int HW = (HOLD_CYCLES > 1)  ? $clog2(HOLD_CYCLES)  : 1;
  localparam int BW = (IF_LEN > 1)       ? $clog2(IF_LEN)       : 1;
  localparam int PW = (PE_X_SIZE > 1)    ? $clog2(PE_X_SIZE)    : 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_PROG, S_GAP, S_STREAM, S_DRAIN} state_t;

  state_t state, state_n;
  logic [SW-1:0] scan_idx, scan_idx_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic [BW-1:0] beat_idx, beat_idx_n;
  logic [PW-1:0] pass_idx, pass_idx_n;
  logic [DW-1:0] drain_cnt, drain_cnt_n;

  logic                    prog_en_q;
  logic [TAG_LENGTH-1:0]   row_tag_q;
  logic [ADDR_WIDTH-1:0]   ifmap_addr_n, filter_addr_n;
  logic                    en_if_q, en_f_q;
  logic [2*TAG_LENGTH-1:0] tag_if_q, tag_f_q;

  logic [TAG_LENGTH-1:0] ifmap_tbl  [SCAN_LEN];
  logic [TAG_LENGTH-1:0] filter_tbl [SCAN_LEN];

  // Tag table survives reset so a job can be rerun after an abort.
  always_ff @(posedge clk) begin
    if (cfg_wr_en && int'(cfg_wr_addr) < SCAN_LEN) begin
      ifmap_tbl[cfg_wr_addr[SW-1:0]]  <= cfg_wr_ifmap_id;
      filter_tbl[cfg_wr_addr[SW-1:0]] <= cfg_wr_filter_id;
    end
  end

  always_comb begin
    state_n     = state;
    scan_idx_n  = scan_idx;
    hold_cnt_n  = hold_cnt;
    beat_idx_n  = beat_idx;
    pass_idx_n  = pass_idx;
    drain_cnt_n = drain_cnt;
    program_en  = 1'b0;
    pe_reset    = 1'b1;
    busy        = 1'b1;
    done        = 1'b0;
    scan_chain_input_ifmap  = '0;
    scan_chain_input_filter = '0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_n = S_CLR;
      end
      S_CLR: begin
        pe_reset   = 1'b0;
        scan_idx_n = '0;
        hold_cnt_n = '0;
        beat_idx_n = '0;
        pass_idx_n = '0;
        state_n    = prog_en_q ? S_PROG : S_STREAM;
      end
      S_PROG: begin
        program_en              = 1'b1;
        scan_chain_input_ifmap  = ifmap_tbl[scan_idx];
        scan_chain_input_filter = filter_tbl[scan_idx];
        if (int'(hold_cnt) == HOLD_CYCLES-1) begin
          hold_cnt_n = '0;
          if (int'(scan_idx) == SCAN_LEN-1) state_n = S_GAP;
          else scan_idx_n = scan_idx + SW'(1);
        end else begin
          hold_cnt_n = hold_cnt + HW'(1);
        end
      end
      S_GAP: begin
        beat_idx_n = '0;
        pass_idx_n = '0;
        state_n    = S_STREAM;
      end
      S_STREAM: begin
        if (int'(beat_idx) == IF_LEN-1) begin
          beat_idx_n = '0;
          if (int'(pass_idx) == PE_X_SIZE-1) begin
            pass_idx_n  = '0;
            drain_cnt_n = '0;
            state_n     = S_DRAIN;
          end else begin
            pass_idx_n = pass_idx + PW'(1);
          end
        end else begin
          beat_idx_n = beat_idx + BW'(1);
        end
      end
      S_DRAIN: begin
        if (int'(drain_cnt) == DRAIN_CYCLES-1) begin
          done    = 1'b1;
          state_n = S_IDLE;
        end else begin
          drain_cnt_n = drain_cnt + DW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Addresses are computed from the next-cycle counters so the registered value lines up with its request cycle.
  always_comb begin
    ifmap_addr_n  = '0;
    filter_addr_n = '0;
    if (state_n == S_STREAM) begin
      ifmap_addr_n = ADDR_WIDTH'(pass_idx_n) * ADDR_WIDTH'(IF_LEN) + ADDR_WIDTH'(beat_idx_n);
      if (int'(beat_idx_n) < PE_Y_SIZE)
        filter_addr_n = ADDR_WIDTH'(pass_idx_n) * ADDR_WIDTH'(PE_Y_SIZE) + ADDR_WIDTH'(beat_idx_n);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= S_IDLE;
      scan_idx    <= '0;
      hold_cnt    <= '0;
      beat_idx    <= '0;
      pass_idx    <= '0;
      drain_cnt   <= '0;
      prog_en_q   <= 1'b0;
      row_tag_q   <= '0;
      ifmap_addr  <= '0;
      filter_addr <= '0;
      en_if_q     <= 1'b0;
      en_f_q      <= 1'b0;
      tag_if_q    <= '0;
      tag_f_q     <= '0;
    end else begin
      state       <= state_n;
      scan_idx    <= scan_idx_n;
      hold_cnt    <= hold_cnt_n;
      beat_idx    <= beat_idx_n;
      pass_idx    <= pass_idx_n;
      drain_cnt   <= drain_cnt_n;
      ifmap_addr  <= ifmap_addr_n;
      filter_addr <= filter_addr_n;
      en_if_q     <= (state == S_STREAM);
      en_f_q      <= (state == S_STREAM) && (int'(beat_idx) < PE_Y_SIZE);
      tag_if_q    <= {row_tag_q, TAG_LENGTH'(beat_idx)};
      tag_f_q     <= {row_tag_q, TAG_LENGTH'(pass_idx)};
      if (state == S_IDLE && start) begin
        prog_en_q <= cfg_prog_en;
        row_tag_q <= cfg_row_tag;
      end
    end
  end

  assign gin_enable_ifmap   = en_if_q;
  assign gin_enable_filter  = en_f_q;
  assign data_packet_ifmap  = en_if_q ? {tag_if_q, ifmap_rdata}  : '0;
  assign data_packet_filter = en_f_q  ? {tag_f_q,  filter_rdata} : '0;

endmodule
